// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the fetch path: widths, the canonical NOP,
// and the instruction-buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Instructions are word aligned; low two bits of a target are ignored.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of fetch entries with a synchronous flush.
// Storage is left unreset; only the pointers and the occupancy count are reset.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    // Upstream credit accounting must make this impossible.
    overflow_check: assert property (
        @(posedge clk) disable iff (rst) !(push && full)
    );

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// tracking, redirect flush with stale-response dropping, and a decode buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW:0]     credit_used;

    logic [XLEN-1:0] inflight [DEPTH];
    logic [PW-1:0]   ifl_rd;
    logic [PW-1:0]   ifl_wr;

    logic            accept;
    logic            buf_push;
    logic            buf_pop;
    logic            buf_empty;
    logic [CW-1:0]   buf_count;
    fetch_entry_t    buf_head;
    fetch_entry_t    rsp_entry;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Buffered words count against credit so the buffer can never overflow.
    assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req    = !rst && !redirect && (credit_used < CREDITS);
    assign imem_addr   = pc_q;
    assign accept      = imem_req && imem_ready;

    assign rsp_entry.instr = imem_rsp_data;
    assign rsp_entry.pc    = inflight[ifl_rd];

    assign buf_push = imem_rsp_valid && !redirect && (drop_cnt == '0);
    assign if_valid = !rst && !buf_empty && !redirect;
    assign buf_pop  = if_valid && !stall;
    assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? buf_head.pc : pc_q;

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (buf_push),
        .push_data(rsp_entry),
        .pop      (buf_pop),
        .clear    (redirect),
        .head     (buf_head),
        .count    (buf_count),
        .empty    (buf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            ifl_rd      <= '0;
            ifl_wr      <= '0;
        end else begin
            if (redirect)
                pc_q <= align_pc(redirect_pc);
            else if (accept)
                pc_q <= pc_q + XLEN'(4);

            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);

            // A response landing in the redirect cycle is already discarded,
            // so only the requests still pending afterwards need dropping.
            if (redirect)
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            else if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);

            if (accept)         ifl_wr <= next_ptr(ifl_wr);
            if (imem_rsp_valid) ifl_rd <= next_ptr(ifl_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) inflight[ifl_wr] <= pc_q;
    end

    rsp_without_request: assert property (
        @(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (outstanding == '0))
    );

    outstanding_bound: assert property (
        @(posedge clk) disable iff (rst)
        credit_used <= CREDITS
    );

endmodule
